// File: rtl/contador_bounce.sv
// rtl/contador_bounce.sv - bounded up/down/bounce counter; CONTADOR_BOUNCE_HOLD_EN adds endpoint hold states
module contador_bounce #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] s,
  output logic             dir,
  output logic             tc,
  output logic             err
);

  typedef enum logic [1:0] {
    UP      = 2'd0,
    DOWN    = 2'd1,
    HOLD_HI = 2'd2,
    HOLD_LO = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t state;

  logic [WIDTH-1:0] s_inc;
  logic [WIDTH-1:0] s_dec;
  logic [WIDTH-1:0] hi_m1;
  logic [WIDTH-1:0] lo_p1;
  logic             in_range;
  logic             bound_bad;

  // step candidates; only used when lo < hi, so none of them can wrap
  always_comb begin
    s_inc     = s + ONE;
    s_dec     = s - ONE;
    hi_m1     = hi - ONE;
    lo_p1     = lo + ONE;
    in_range  = (s >= lo) && (s <= hi);
    bound_bad = (lo >= hi);
  end

  // counter state machine: clear > load > bound error > enable > hold
  always_ff @(posedge clock) begin
    if (clear) begin
      s     <= '0;
      dir   <= 1'b0;
      tc    <= 1'b0;
      err   <= 1'b0;
      state <= UP;
    end else if (load) begin
      s  <= load_val;
      tc <= 1'b0;
      if (state == HOLD_HI) state <= DOWN;
      else if (state == HOLD_LO) state <= UP;
    end else if (bound_bad) begin
      err <= 1'b1;
      tc  <= 1'b0;
    end else begin
      err <= 1'b0;
      if (!en) begin
        tc <= 1'b0;
      end else begin
        case (mode)
          2'b00: begin
            dir   <= 1'b0;
            state <= UP;
            if (!in_range || s == hi) begin
              s  <= lo;
              tc <= 1'b0;
            end else begin
              s  <= s_inc;
              tc <= (s_inc == hi);
            end
          end
          2'b01: begin
            dir   <= 1'b1;
            state <= DOWN;
            if (!in_range || s == lo) begin
              s  <= hi;
              tc <= 1'b0;
            end else begin
              s  <= s_dec;
              tc <= (s_dec == lo);
            end
          end
          default: begin
            case (state)
              UP: begin
                if (!in_range) begin
                  s  <= lo;
                  tc <= 1'b0;
                end else if (s == hi) begin
`ifdef CONTADOR_BOUNCE_HOLD_EN
                  state <= HOLD_HI;
                  tc    <= 1'b0;
`else
                  s     <= hi_m1;
                  dir   <= 1'b1;
                  state <= DOWN;
                  tc    <= (hi_m1 == lo);
`endif
                end else begin
                  s  <= s_inc;
                  tc <= (s_inc == hi);
                end
              end
              DOWN: begin
                if (!in_range) begin
                  s  <= hi;
                  tc <= 1'b0;
                end else if (s == lo) begin
`ifdef CONTADOR_BOUNCE_HOLD_EN
                  state <= HOLD_LO;
                  tc    <= 1'b0;
`else
                  s     <= lo_p1;
                  dir   <= 1'b0;
                  state <= UP;
                  tc    <= (lo_p1 == hi);
`endif
                end else begin
                  s  <= s_dec;
                  tc <= (s_dec == lo);
                end
              end
              HOLD_HI: begin
                s     <= hi_m1;
                dir   <= 1'b1;
                state <= DOWN;
                tc    <= (hi_m1 == lo);
              end
              default: begin
                s     <= lo_p1;
                dir   <= 1'b0;
                state <= UP;
                tc    <= (lo_p1 == hi);
              end
            endcase
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_contador_bounce.sv
// tb/tb_contador_bounce.sv - scoreboard bench for contador_bounce
module tb_contador_bounce;

  logic       clock;
  logic       clear;
  logic       en;
  logic [1:0] mode;
  logic [3:0] lo;
  logic [3:0] hi;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] s;
  logic       dir;
  logic       tc;
  logic       err;

  typedef struct {
    logic [3:0] s;
    logic       dir;
    logic       tc;
    logic       err;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  contador_bounce #(.WIDTH(4)) dut (
    .clock    (clock),
    .clear    (clear),
    .en       (en),
    .mode     (mode),
    .lo       (lo),
    .hi       (hi),
    .load     (load),
    .load_val (load_val),
    .s        (s),
    .dir      (dir),
    .tc       (tc),
    .err      (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // one clock edge with the current inputs, then queue what that edge must produce
  task automatic step(input int es, input logic edir, input logic etc,
                      input logic eerr, input string nm);
    exp_t e;
    @(posedge clock);
    #1;
    e.s    = 4'(es);
    e.dir  = edir;
    e.tc   = etc;
    e.err  = eerr;
    e.name = nm;
    sb.push_back(e);
  endtask

  // monitor: outputs are settled mid-cycle, compare against the oldest expectation
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      m_e = sb.pop_front();
      n_cmp++;
      if (s !== m_e.s || dir !== m_e.dir || tc !== m_e.tc || err !== m_e.err) begin
        n_bad++;
        $display("FAIL %s: got s=%0d dir=%0b tc=%0b err=%0b, want s=%0d dir=%0b tc=%0b err=%0b",
                 m_e.name, s, dir, tc, err, m_e.s, m_e.dir, m_e.tc, m_e.err);
      end
    end
  end

  initial begin
    clear = 1'b1; en = 1'b0; mode = 2'b00; lo = 4'd0; hi = 4'd15;
    load = 1'b0; load_val = 4'd0;
    step(0, 0, 0, 0, "reset");
    step(0, 0, 0, 0, "reset_hold");

    // full bounce cycle over 0..15
    clear = 1'b0; en = 1'b1; mode = 2'b10;
    for (int i = 1; i <= 15; i++) step(i, 0, (i == 15), 0, "bounce_up");
`ifdef CONTADOR_BOUNCE_HOLD_EN
    step(15, 0, 0, 0, "hold_hi");
`endif
    for (int i = 14; i >= 0; i--) step(i, 1, (i == 0), 0, "bounce_down");
`ifdef CONTADOR_BOUNCE_HOLD_EN
    step(0, 1, 0, 0, "hold_lo");
`endif
    step(1, 0, 0, 0, "bounce_turn");
    step(2, 0, 0, 0, "bounce_up2");

    // clear aborts mid-count, then clear beats load at the top endpoint
    clear = 1'b1; step(0, 0, 0, 0, "clear_mid");
    clear = 1'b0;
    for (int i = 1; i <= 15; i++) step(i, 0, (i == 15), 0, "recount");
`ifdef CONTADOR_BOUNCE_HOLD_EN
    step(15, 0, 0, 0, "hold_hi2");
`endif
    clear = 1'b1; load = 1'b1; load_val = 4'd7;
    step(0, 0, 0, 0, "clear_over_load");
    clear = 1'b0; load = 1'b0;
    step(1, 0, 0, 0, "after_clear");
    step(2, 0, 0, 0, "after_clear2");

    // up-wrap 3..6 then down-wrap
    clear = 1'b1; step(0, 0, 0, 0, "clear2");
    clear = 1'b0; mode = 2'b00; lo = 4'd3; hi = 4'd6;
    step(3, 0, 0, 0, "up_snap");
    step(4, 0, 0, 0, "up_wrap");
    step(5, 0, 0, 0, "up_wrap");
    step(6, 0, 1, 0, "up_tc");
    step(3, 0, 0, 0, "up_wrap_lo");
    step(4, 0, 0, 0, "up_wrap");
    mode = 2'b01;
    step(3, 1, 1, 0, "down_tc");
    step(6, 1, 0, 0, "down_wrap_hi");
    step(5, 1, 0, 0, "down_wrap");
    step(4, 1, 0, 0, "down_wrap");
    step(3, 1, 1, 0, "down_tc2");
    step(6, 1, 0, 0, "down_wrap_hi2");

    // out-of-range load while bouncing up
    clear = 1'b1; mode = 2'b10; lo = 4'd0; hi = 4'd15;
    step(0, 0, 0, 0, "clear3");
    clear = 1'b0;
    for (int i = 1; i <= 9; i++) step(i, 0, 0, 0, "count_to_9");
    load = 1'b1; load_val = 4'd12; hi = 4'd10;
    step(12, 0, 0, 0, "load_oor");
    load = 1'b0;
    step(0, 0, 0, 0, "snap_lo");
    hi = 4'd15;
    for (int i = 1; i <= 10; i++) step(i, 0, 0, 0, "count_to_10");

    // bound error freezes, recovery resumes from frozen value
    lo = 4'd8; hi = 4'd8;
    step(10, 0, 0, 1, "err_freeze");
    step(10, 0, 0, 1, "err_freeze");
    step(10, 0, 0, 1, "err_freeze");
    hi = 4'd12;
    step(11, 0, 0, 0, "err_clear");
    step(12, 0, 1, 0, "resume_tc");

    // enable low freezes; bound error still wins over enable
    en = 1'b0;
    step(12, 0, 0, 0, "en_freeze");
    step(12, 0, 0, 0, "en_freeze2");
    lo = 4'd12;
    step(12, 0, 0, 1, "err_while_idle");
    lo = 4'd8; en = 1'b1;
`ifdef CONTADOR_BOUNCE_HOLD_EN
    step(12, 0, 0, 0, "hi_endpoint_hold");
    step(11, 1, 0, 0, "hi_endpoint_down");
`else
    step(11, 1, 0, 0, "hi_endpoint_down");
    step(10, 1, 0, 0, "down_after_turn");
`endif

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clock);
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
